dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Arbitrates and sequences a single-port, word-wide data memory between two requesters: port 0 is the core load/store unit, port 1 is a loader/debug master.
- The memory has a 1-cycle registered read latency and separate mem_read/mem_write strobes.
- The block adds byte/halfword loads with sign or zero extension, sub-word stores via read-modify-write, and misalignment detection.
- It sits between the execute/memory stage and data_mem.

Parameters:
- width, 32, data and address width of all request and memory buses.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- req0_valid / req1_valid  in  1  request present; held stable until accepted.
- req0_ready / req1_ready  out  1  request accepted this cycle when valid&ready.
- req0_we / req1_we  in  1  1 = store, 0 = load.
- req0_size / req1_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req0_uns / req1_uns  in  1  load zero-extend when 1, sign-extend when 0.
- req0_addr / req1_addr  in  width  byte address.
- req0_wdata / req1_wdata  in  width  store data, right-aligned.
- rsp0_valid / rsp1_valid  out  1  one-cycle completion pulse.
- rsp0_rdata / rsp1_rdata  out  width  extended load data; 0 for stores and errors.
- rsp0_err / rsp1_err  out  1  misaligned or illegal-size request; valid with rspN_valid.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_addr  out  width  word-aligned address, {addr[width-1:2],2'b00}.
- mem_wdata  out  width  memory write data.
- mem_rdata  in  width  memory read data, valid the cycle after mem_read.

Behaviour:
- States: IDLE, CMD, LRESP, MERGE, ERR. Reset forces IDLE.
- Reset values: all outputs 0; round-robin pointer favours port 0; captured request registers 0.
- IDLE:
  - One valid only: that port wins.
  - Both valid: the port not granted last wins. The pointer updates on each accept.
  - readyN = (state==IDLE) & winner==N. Never both high.
  - On accept (cycle T): capture port id, we, size, uns, addr, wdata.
  - Alignment check at accept: half with addr[0]=1, word with addr[1:0]!=0, or size=11 -> ERR. Otherwise -> CMD.
- CMD (T+1): mem_addr from the captured address.
  - Word store: mem_write=1, mem_wdata=wdata, rsp_valid=1, -> IDLE.
  - Load or sub-word store: mem_read=1. Load -> LRESP, sub-word store -> MERGE.
- LRESP (T+2): select lane by addr[1:0]: byte at bits 8*addr[1:0]+7..8*addr[1:0], half at bits 16*addr[1]+15..16*addr[1]. Extend per uns. rsp_valid=1, rsp_rdata=result, -> IDLE.
- MERGE (T+2): mem_write=1, mem_wdata = mem_rdata with the addressed byte/half lane replaced by wdata[7:0] or wdata[15:0]. rsp_valid=1, -> IDLE.
- ERR (T+1): rsp_valid=1, rsp_err=1, rsp_rdata=0; no memory strobe; -> IDLE.
- Response routing: responses go only to the captured port. The other port's rsp signals stay 0.
- Latency, accept to rsp_valid: word store 1, error 1, load 2, sub-word store 2.
- Throughput: the next accept happens in the IDLE cycle after completion.
- mem_read and mem_write are never high together. Both are 0 in IDLE, LRESP and ERR.
- mem_addr and mem_wdata are 0 whenever no strobe is high.
- Requester dropping valid before ready is illegal; the block behaviour is unspecified.
- Reset mid-operation: abort the transaction, produce no response, and assert no strobe in the cycle after reset.

Test Plan:
- Port 0 word load addr 0x8, memory holds 0x38 -> mem_read at T+1 with mem_addr 0x8; rsp0_valid at T+2 with rdata 0x00000038, err 0.
- Port 1 signed byte load addr 0x21, word 0x000080b3 -> rsp1_rdata 0xFFFFFF80; the same load with uns=1 -> 0x00000080.
- Port 0 half store 0xBEEF to addr 0x12, word 0x00000055 -> T+1 mem_read, T+2 mem_write with data 0xBEEF0055; rsp0_valid at T+2.
- Both ports valid continuously with word stores -> grants alternate 0,1,0,1; each store completes in 2 cycles; ready never high on both ports.
- Word load at addr 0x6 and access with size 11 -> rsp_err=1 at T+1; no mem_read/mem_write pulse.
- rst asserted in MERGE of a sub-word store -> no mem_write, no rsp_valid; all outputs 0; next simultaneous request grants port 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and sequencer for a single-port word memory with 1-cycle read latency.
// Adds sub-word loads with sign/zero extension, sub-word stores by read-modify-write, and misalignment errors.
module dmem_arbiter #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic             req0_we,
    input  logic [1:0]       req0_size,
    input  logic             req0_uns,
    input  logic [width-1:0] req0_addr,
    input  logic [width-1:0] req0_wdata,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic             req1_we,
    input  logic [1:0]       req1_size,
    input  logic             req1_uns,
    input  logic [width-1:0] req1_addr,
    input  logic [width-1:0] req1_wdata,
    output logic             rsp0_valid,
    output logic [width-1:0] rsp0_rdata,
    output logic             rsp0_err,
    output logic             rsp1_valid,
    output logic [width-1:0] rsp1_rdata,
    output logic             rsp1_err,
    output logic             mem_read,
    output logic             mem_write,
    output logic [width-1:0] mem_addr,
    output logic [width-1:0] mem_wdata,
    input  logic [width-1:0] mem_rdata,
    output logic [2:0]       dbg_state_o
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CMD   = 3'd1;
    localparam logic [2:0] LRESP = 3'd2;
    localparam logic [2:0] MERGE = 3'd3;
    localparam logic [2:0] ERR   = 3'd4;

    logic [2:0]       state_q, state_d;
    logic             rr_q;        // port favoured when both request
    logic             port_q, we_q, uns_q;
    logic [1:0]       size_q;
    logic [width-1:0] addr_q, wdata_q;

    logic             grant1, accept;
    logic             sel_we, sel_uns, sel_bad;
    logic [1:0]       sel_size;
    logic [width-1:0] sel_addr, sel_wdata;

    logic [4:0]       lane_sh;
    logic [width-1:0] shifted, load_ext, lane_mask, lane_ins, merged, word_addr;

    logic             rsp_v, rsp_e;
    logic [width-1:0] rsp_d;

    // Handshake: a request transfers on the rising edge where valid and ready are both high;
    // ready is only offered in IDLE and only to the winning port, and valid must hold until then.
    always_comb begin
        grant1    = (req0_valid && req1_valid) ? rr_q : req1_valid;
        accept    = (state_q == IDLE) && (req0_valid || req1_valid) && !rst;
        sel_we    = grant1 ? req1_we    : req0_we;
        sel_size  = grant1 ? req1_size  : req0_size;
        sel_uns   = grant1 ? req1_uns   : req0_uns;
        sel_addr  = grant1 ? req1_addr  : req0_addr;
        sel_wdata = grant1 ? req1_wdata : req0_wdata;
        sel_bad   = (sel_size == 2'b11)
                  || ((sel_size == 2'b01) && sel_addr[0])
                  || ((sel_size == 2'b10) && (sel_addr[1:0] != 2'b00));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = sel_bad ? ERR : CMD;
            CMD:     state_d = (we_q && size_q == 2'b10) ? IDLE : (we_q ? MERGE : LRESP);
            LRESP:   state_d = IDLE;
            MERGE:   state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            port_q  <= 1'b0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                rr_q    <= ~grant1;
                port_q  <= grant1;
                we_q    <= sel_we;
                size_q  <= sel_size;
                uns_q   <= sel_uns;
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
            end
        end
    end

    // Half accesses are known to be aligned here, so the byte shift also gives 16*addr[1].
    always_comb begin
        lane_sh   = {addr_q[1:0], 3'b000};
        word_addr = {addr_q[width-1:2], 2'b00};
        shifted   = mem_rdata >> lane_sh;
        case (size_q)
            2'b00:   load_ext = uns_q ? {{(width-8){1'b0}}, shifted[7:0]}
                                      : {{(width-8){shifted[7]}}, shifted[7:0]};
            2'b01:   load_ext = uns_q ? {{(width-16){1'b0}}, shifted[15:0]}
                                      : {{(width-16){shifted[15]}}, shifted[15:0]};
            default: load_ext = mem_rdata;
        endcase
        if (size_q == 2'b00) begin
            lane_mask = {{(width-8){1'b0}}, 8'hFF} << lane_sh;
            lane_ins  = {{(width-8){1'b0}}, wdata_q[7:0]} << lane_sh;
        end else begin
            lane_mask = {{(width-16){1'b0}}, 16'hFFFF} << lane_sh;
            lane_ins  = {{(width-16){1'b0}}, wdata_q[15:0]} << lane_sh;
        end
        merged = (mem_rdata & ~lane_mask) | (lane_ins & lane_mask);
    end

    // All outputs are forced low while reset is held so an aborted operation leaves no trace.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_v      = 1'b0;
        rsp_e      = 1'b0;
        rsp_d      = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    req0_ready = req0_valid && !grant1;
                    req1_ready = grant1;
                end
                CMD: begin
                    mem_addr = word_addr;
                    if (we_q && size_q == 2'b10) begin
                        mem_write = 1'b1;
                        mem_wdata = wdata_q;
                        rsp_v     = 1'b1;
                    end else begin
                        mem_read = 1'b1;
                    end
                end
                LRESP: begin
                    rsp_v = 1'b1;
                    rsp_d = load_ext;
                end
                MERGE: begin
                    mem_write = 1'b1;
                    mem_addr  = word_addr;
                    mem_wdata = merged;
                    rsp_v     = 1'b1;
                end
                ERR: begin
                    rsp_v = 1'b1;
                    rsp_e = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign rsp0_valid  = rsp_v && !port_q;
    assign rsp1_valid  = rsp_v && port_q;
    assign rsp0_err    = rsp_e && !port_q;
    assign rsp1_err    = rsp_e && port_q;
    assign rsp0_rdata  = port_q ? '0 : rsp_d;
    assign rsp1_rdata  = port_q ? rsp_d : '0;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized scoreboard bench for dmem_arbiter: a transaction-level reference model predicts
// responses, memory strobes and grants; a negedge monitor compares everything the DUT presents.
module tb_dmem_arbiter;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;

  logic req_valid [2];
  logic req_ready [2];
  logic req_we [2];
  logic [1:0] req_size [2];
  logic req_uns [2];
  logic [W-1:0] req_addr [2];
  logic [W-1:0] req_wdata [2];

  logic rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [W-1:0] rsp0_rdata, rsp1_rdata;
  logic mem_read, mem_write;
  logic [W-1:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0] dbg_state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_arbiter #(.width(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req_valid[0]), .req0_ready(req_ready[0]), .req0_we(req_we[0]),
    .req0_size(req_size[0]), .req0_uns(req_uns[0]), .req0_addr(req_addr[0]),
    .req0_wdata(req_wdata[0]),
    .req1_valid(req_valid[1]), .req1_ready(req_ready[1]), .req1_we(req_we[1]),
    .req1_size(req_size[1]), .req1_uns(req_uns[1]), .req1_addr(req_addr[1]),
    .req1_wdata(req_wdata[1]),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dbg_state_o(dbg_state)
  );

  // ---------------- memory attached to the DUT ----------------
  logic [W-1:0] dmem [16];
  always @(posedge clk) begin
    if (mem_write) dmem[mem_addr[5:2]] <= mem_wdata;
    if (mem_read) mem_rdata <= dmem[mem_addr[5:2]];
  end

  // ---------------- reference model state ----------------
  typedef struct {
    int port;
    bit err;
    logic [W-1:0] rdata;
    int cyc;
    bit upd;
    int widx;
    logic [W-1:0] wnew;
  } exp_t;

  exp_t exp_q[$];
  logic [W-1:0] ref_mem [16];
  bit exp_rd [int];
  bit exp_wr [int];
  logic [W-1:0] exp_addr [int];
  logic [W-1:0] exp_wd [int];
  int last_grant = 1;
  int next_free = 0;
  logic [W-1:0] last_rdata [2];

  int vectors = 0;
  int miscompares = 0;

  // Predicted behaviour of one accepted request, from the access rules alone.
  task automatic model_accept(input int p, input int c);
    logic [W-1:0] a, w, nw, wd, rd;
    logic [1:0] sz;
    int off, wi, lat;
    bit err;
    exp_t e;
    a = req_addr[p]; sz = req_size[p]; wd = req_wdata[p];
    off = int'(a[1:0]);
    wi = int'(a[5:2]);
    w = ref_mem[wi];
    err = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    e.port = p; e.err = err; e.rdata = '0; e.upd = 0; e.widx = wi; e.wnew = '0;
    if (err) begin
      lat = 1;
    end else if (req_we[p] && sz == 2'b10) begin
      lat = 1;
      exp_wr[c+1] = 1; exp_addr[c+1] = {a[W-1:2], 2'b00}; exp_wd[c+1] = wd;
      e.upd = 1; e.wnew = wd;
    end else begin
      lat = 2;
      exp_rd[c+1] = 1; exp_addr[c+1] = {a[W-1:2], 2'b00};
      if (req_we[p]) begin
        nw = w;
        if (sz == 2'b00) nw[8*off +: 8] = wd[7:0];
        else nw[8*off +: 16] = wd[15:0];
        exp_wr[c+2] = 1; exp_addr[c+2] = {a[W-1:2], 2'b00}; exp_wd[c+2] = nw;
        e.upd = 1; e.wnew = nw;
      end else begin
        if (sz == 2'b00) begin
          rd = W'(w[8*off +: 8]);
          if (!req_uns[p] && rd[7]) rd = rd - 32'h100;
        end else if (sz == 2'b01) begin
          rd = W'(w[8*off +: 16]);
          if (!req_uns[p] && rd[15]) rd = rd - 32'h10000;
        end else begin
          rd = w;
        end
        e.rdata = rd;
      end
    end
    e.cyc = c + lat;
    next_free = c + lat + 1;
    last_grant = p;
    exp_q.push_back(e);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    exp_t e;
    logic [1:0] rv, erv, rdy, erdy;
    logic erd, ewr, gerr;
    logic [W-1:0] eaddr, ewd, gd;
    if (rst) begin
      vectors++;
      if ({req_ready[1], req_ready[0], rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, mem_read, mem_write} != 0
          || rsp0_rdata != 0 || rsp1_rdata != 0 || mem_addr != 0 || mem_wdata != 0) begin
        miscompares++;
        $display("FAIL reset_outputs cyc=%0d got rdy=%b%b rv=%b%b rd=%b wr=%b addr=%h wd=%h need all 0",
                 cyc, req_ready[1], req_ready[0], rsp1_valid, rsp0_valid, mem_read, mem_write, mem_addr, mem_wdata);
      end
      exp_q.delete(); exp_rd.delete(); exp_wr.delete(); exp_addr.delete(); exp_wd.delete();
      last_grant = 1;
      next_free = cyc + 1;
    end else begin
      // memory strobes
      erd = exp_rd.exists(cyc);
      ewr = exp_wr.exists(cyc);
      eaddr = (erd || ewr) ? exp_addr[cyc] : '0;
      ewd = ewr ? exp_wd[cyc] : '0;
      vectors++;
      if (mem_read !== erd || mem_write !== ewr || mem_addr !== eaddr || mem_wdata !== ewd) begin
        miscompares++;
        $display("FAIL mem_strobe cyc=%0d got rd=%b wr=%b addr=%h wd=%h need rd=%b wr=%b addr=%h wd=%h",
                 cyc, mem_read, mem_write, mem_addr, mem_wdata, erd, ewr, eaddr, ewd);
      end
      // responses
      rv = {rsp1_valid, rsp0_valid};
      if (rv != 2'b00 || (exp_q.size() > 0 && exp_q[0].cyc <= cyc)) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL rsp_unexpected cyc=%0d got valid=%b need none", cyc, rv);
        end else begin
          e = exp_q.pop_front();
          erv = (e.port == 1) ? 2'b10 : 2'b01;
          gerr = (e.port == 1) ? rsp1_err : rsp0_err;
          gd = (e.port == 1) ? rsp1_rdata : rsp0_rdata;
          if (rv !== erv || gerr !== e.err || gd !== e.rdata || cyc != e.cyc) begin
            miscompares++;
            $display("FAIL rsp cyc=%0d got valid=%b err=%b rdata=%h need valid=%b err=%b rdata=%h at cyc %0d",
                     cyc, rv, gerr, gd, erv, e.err, e.rdata, e.cyc);
          end
          if (e.upd) ref_mem[e.widx] = e.wnew;
          last_rdata[e.port] = gd;
        end
      end
      // inactive response ports stay quiet
      vectors++;
      if ((!rsp0_valid && (rsp0_err || rsp0_rdata != 0)) || (!rsp1_valid && (rsp1_err || rsp1_rdata != 0))) begin
        miscompares++;
        $display("FAIL rsp_idle cyc=%0d got err=%b%b rdata0=%h rdata1=%h need 0", cyc, rsp1_err, rsp0_err, rsp0_rdata, rsp1_rdata);
      end
      // grant: round robin between simultaneous requesters, only when free
      rdy = {req_ready[1], req_ready[0]};
      erdy = 2'b00;
      if (cyc >= next_free) begin
        if (req_valid[0] && req_valid[1]) erdy = (last_grant == 0) ? 2'b10 : 2'b01;
        else erdy = {req_valid[1], req_valid[0]};
      end
      vectors++;
      if (rdy !== erdy) begin
        miscompares++;
        $display("FAIL ready cyc=%0d got %b need %b", cyc, rdy, erdy);
      end
      for (int p = 0; p < 2; p++)
        if (req_valid[p] && req_ready[p]) model_accept(p, cyc);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input int p, input bit we, input logic [1:0] sz, input bit uns,
                       input logic [W-1:0] a, input logic [W-1:0] wd);
    int t;
    req_valid[p] = 1'b1; req_we[p] = we; req_size[p] = sz; req_uns[p] = uns;
    req_addr[p] = a; req_wdata[p] = wd;
    t = 0;
    while (1) begin
      @(negedge clk);
      if (req_ready[p]) break;
      t++;
      if (t > 200) begin
        vectors++;
        miscompares++;
        $display("FAIL accept_timeout port=%0d got no ready need ready within 200 cycles", p);
        break;
      end
    end
    @(posedge clk);
    #1;
    req_valid[p] = 1'b0;
  endtask

  task automatic rand_port(input int p, input int n);
    int r;
    logic [1:0] sz;
    logic [W-1:0] a;
    for (int i = 0; i < n; i++) begin
      idle($urandom_range(0, 3));
      r = $urandom_range(0, 9);
      sz = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      a = W'($urandom_range(0, 63));
      if ($urandom_range(0, 4) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      issue(p, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
    end
  endtask

  task automatic check_const(input string name, input logic [W-1:0] got, input logic [W-1:0] need);
    vectors++;
    if (got !== need) begin
      miscompares++;
      $display("FAIL %s got %h need %h", name, got, need);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int p = 0; p < 2; p++) begin
      req_valid[p] = 0; req_we[p] = 0; req_size[p] = 0; req_uns[p] = 0;
      req_addr[p] = 0; req_wdata[p] = 0; last_rdata[p] = 0;
    end
    for (int i = 0; i < 16; i++) dmem[i] = $urandom;
    dmem[2] = 32'h0000_0038;
    dmem[8] = 32'h0000_80b3;
    dmem[4] = 32'h0000_0055;
    for (int i = 0; i < 16; i++) ref_mem[i] = dmem[i];
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(2);

    issue(0, 0, 2'b10, 0, 32'h8, 0);
    idle(3);
    check_const("word_load_p0", last_rdata[0], 32'h0000_0038);
    issue(1, 0, 2'b00, 0, 32'h21, 0);
    idle(3);
    check_const("byte_load_signed_p1", last_rdata[1], 32'hFFFF_FF80);
    issue(1, 0, 2'b00, 1, 32'h21, 0);
    idle(3);
    check_const("byte_load_unsigned_p1", last_rdata[1], 32'h0000_0080);
    issue(0, 1, 2'b01, 0, 32'h12, 32'h0000_BEEF);
    idle(3);
    check_const("half_store_merge", dmem[4], 32'hBEEF_0055);
    issue(0, 0, 2'b10, 0, 32'h6, 0);
    issue(1, 0, 2'b11, 0, 32'h10, 0);
    idle(3);

    fork
      for (int i = 0; i < 4; i++) issue(0, 1, 2'b10, 0, W'(32 + 4*i), $urandom);
      for (int i = 0; i < 4; i++) issue(1, 1, 2'b10, 0, W'(48 + 4*i), $urandom);
    join
    idle(3);

    // reset lands in the merge cycle of a sub-word store
    issue(0, 1, 2'b00, 0, 32'h3, 32'h0000_00A5);
    idle(1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    fork
      issue(0, 1, 2'b10, 0, 32'h0, 32'h1111_1111);
      issue(1, 1, 2'b10, 0, 32'h4, 32'h2222_2222);
    join
    idle(3);

    fork
      rand_port(0, 150);
      rand_port(1, 150);
    join
    idle(5);

    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d pending responses need 0", exp_q.size());
    end
    for (int i = 0; i < 16; i++) begin
      vectors++;
      if (dmem[i] !== ref_mem[i]) begin
        miscompares++;
        $display("FAIL mem_final word %0d got %h need %h", i, dmem[i], ref_mem[i]);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    miscompares++;
    $display("FAIL watchdog got no completion need finish before time limit");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
